fb_scan_arbiter: RTL and testbench

- Controller and arbiter for a double-buffered 320x240 RGB332 frame buffer held in one single-port synchronous RAM.
- Sits between the `vga` timing block and the frame-buffer RAM.
- Display reads are scheduled from `hc_out`/`vc_out` with lookahead, so `vga` receives the correct `input_red`/`input_green`/`input_blue` for every active pixel at 2x pixel doubling.
- A writer (camera/host) gets every RAM slot the display does not need. Front/back buffer swaps are applied only at the start of vertical blanking.

---
 rtl/fb_scan_arbiter_if.sv | 31 +++
 rtl/fb_scan_arbiter.sv | 92 +++++++++
 tb/tb_fb_scan_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fb_scan_arbiter_if.sv
// fb_scan_arbiter_if: scan counters, writer handshake, swap control, RAM port and pixel output
interface fb_scan_arbiter_if;
   logic [9:0]  hc_out;
   logic [9:0]  vc_out;
   logic        wr_valid;
   logic        wr_ready;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        swap_req;
   logic        swap_pending;
   logic        swap_done;
   logic        front_buf;
   logic        ram_en;
   logic        ram_we;
   logic [17:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [2:0]  pix_red;
   logic [2:0]  pix_green;
   logic [1:0]  pix_blue;
   modport slave (
      input  hc_out, vc_out, wr_valid, wr_addr, wr_data, swap_req, ram_rdata,
      output wr_ready, swap_pending, swap_done, front_buf, ram_en, ram_we, ram_addr, ram_wdata,
             pix_red, pix_green, pix_blue
   );
   modport master (
      output hc_out, vc_out, wr_valid, wr_addr, wr_data, swap_req, ram_rdata,
      input  wr_ready, swap_pending, swap_done, front_buf, ram_en, ram_we, ram_addr, ram_wdata,
             pix_red, pix_green, pix_blue
   );
endinterface

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: display prefetch and writer arbitration for a double-buffered RGB332 frame buffer
module fb_scan_arbiter #(
   parameter int HACTIVE = 640,
   parameter int VACTIVE = 480,
   parameter int HTOTAL  = 800,
   parameter int VTOTAL  = 525,
   parameter int FB_W    = 320,
   parameter int FB_H    = 240,
   parameter int RAM_LAT = 1
) (
   input logic              vgaclk,
   input logic              rst,
   fb_scan_arbiter_if.slave bus
);
   localparam int LA = 2 + RAM_LAT;
   logic [10:0]      hsum;
   logic             hwrap, tgt_active, read_slot, xfer, wr_ok, do_swap;
   logic [9:0]       th, tv;
   logic [16:0]      rd_idx;
   logic             en_q, en_d, we_q, we_d, front_q, front_d, pend_q, pend_d, done_q, done_d;
   logic [17:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d, pix_q, pix_d;
   logic [RAM_LAT:0] rd_q, rd_d, act_q, act_d;
   // target pixel LA columns ahead, so the RAM data lands exactly when vga shows it
   always_comb begin
      hsum       = {1'b0, bus.hc_out} + 11'(LA);
      hwrap      = hsum >= 11'(HTOTAL);
      th         = hwrap ? 10'(hsum - 11'(HTOTAL)) : hsum[9:0];
      tv         = !hwrap ? bus.vc_out : (bus.vc_out == 10'(VTOTAL - 1)) ? 10'd0 : bus.vc_out + 10'd1;
      tgt_active = (th < 10'(HACTIVE)) && (tv < 10'(VACTIVE));
      read_slot  = tgt_active && !th[0];
      rd_idx     = 17'(tv[9:1]) * 17'(FB_W) + 17'(th[9:1]);
      xfer       = bus.wr_valid && bus.wr_ready;
      wr_ok      = bus.wr_addr < 17'(FB_W * FB_H);
      do_swap    = (bus.hc_out == 10'(HTOTAL - 1)) && (bus.vc_out == 10'(VACTIVE - 1)) && (pend_q || bus.swap_req);
   end
   always_comb begin
      en_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (read_slot) begin
         en_d   = 1'b1;
         addr_d = {front_q, rd_idx};
      end else if (xfer && wr_ok) begin
         en_d    = 1'b1;
         we_d    = 1'b1;
         addr_d  = {~front_q, bus.wr_addr};
         wdata_d = bus.wr_data;
      end
      front_d = front_q ^ do_swap;
      pend_d  = !do_swap && (pend_q || bus.swap_req);
      done_d  = do_swap;
      rd_d    = {rd_q[RAM_LAT-1:0], read_slot};
      act_d   = {act_q[RAM_LAT-1:0], tgt_active};
      pix_d   = !act_q[RAM_LAT] ? 8'd0 : rd_q[RAM_LAT] ? bus.ram_rdata : pix_q;
   end
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         front_q <= 1'b0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= '0;
         act_q   <= '0;
         pix_q   <= '0;
      end else begin
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         front_q <= front_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         act_q   <= act_d;
         pix_q   <= pix_d;
      end
   end
   assign bus.wr_ready     = rst && !read_slot;
   assign bus.ram_en       = en_q;
   assign bus.ram_we       = we_q;
   assign bus.ram_addr     = addr_q;
   assign bus.ram_wdata    = wdata_q;
   assign bus.front_buf    = front_q;
   assign bus.swap_pending = pend_q;
   assign bus.swap_done    = done_q;
   assign {bus.pix_red, bus.pix_green, bus.pix_blue} = pix_q;
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb_fb_scan_arbiter: randomized writer traffic and scan jumps checked against a frame-level reference model
module tb_fb_scan_arbiter;
   logic vgaclk = 1'b0;
   logic rst;
   fb_scan_arbiter_if bus();
   fb_scan_arbiter dut (.vgaclk(vgaclk), .rst(rst), .bus(bus));
   always #5 vgaclk = ~vgaclk;

   logic [7:0] mem [0:262143];
   logic [7:0] fb_ref [0:1][0:76799];
   always @(posedge vgaclk)
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else bus.ram_rdata <= mem[bus.ram_addr];
      end

   int nvec = 0, nerr = 0;
   int h = 0, v = 0, cont = 0, mode = 0;
   int seq = 0;
   bit front_m, pend_m, done_m, en_m, we_m;
   logic [17:0] addr_m;
   logic [7:0] wdata_m;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         if (nerr <= 20) $display("FAIL %s: got %0h expected %0h at h=%0d v=%0d", tag, act, exp, h, v);
      end
   endtask

   function automatic bit rslot(input int hh, input int vv);
      int th = (hh + 3) % 800;
      int tv = (vv + (hh + 3) / 800) % 525;
      return th < 640 && tv < 480 && th % 2 == 0;
   endfunction

   function automatic logic [7:0] exp_pix(input int hh, input int vv);
      return (hh < 640 && vv < 480) ? fb_ref[front_m][(vv / 2) * 320 + hh / 2] : 8'h00;
   endfunction

   task automatic zero_checks();
      chk("rst_ram_en", 32'(bus.ram_en), 0);
      chk("rst_ram_we", 32'(bus.ram_we), 0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 0);
      chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
      chk("rst_pix", 32'({bus.pix_red, bus.pix_green, bus.pix_blue}), 0);
      chk("rst_front", 32'(bus.front_buf), 0);
      chk("rst_pending", 32'(bus.swap_pending), 0);
      chk("rst_done", 32'(bus.swap_done), 0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
   endtask

   task automatic cycle(input bit sreq, input bit arst);
      int th, tv;
      bus.hc_out   = 10'(h);
      bus.vc_out   = 10'(v);
      bus.swap_req = sreq;
      bus.wr_valid = (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.wr_addr  = (mode != 0) ? 17'(seq) :
                     ($urandom_range(0, 15) == 0) ? 17'(76800 + $urandom_range(0, 200)) : 17'($urandom_range(0, 76799));
      bus.wr_data  = 8'($urandom);
      #1;
      chk("wr_ready", 32'(bus.wr_ready), 32'(rst && !rslot(h, v)));
      if (cont >= 4) chk("pix", 32'({bus.pix_red, bus.pix_green, bus.pix_blue}), 32'(exp_pix(h, v)));
      if (arst) begin
         rst = 1'b0;
         #1;
         zero_checks();
      end
      @(posedge vgaclk);
      if (!rst) begin
         {front_m, pend_m, done_m, en_m, we_m} = '0;
         addr_m  = '0;
         wdata_m = '0;
      end else begin
         th = (h + 3) % 800;
         tv = (v + (h + 3) / 800) % 525;
         done_m = 1'b0;
         en_m   = 1'b0;
         we_m   = 1'b0;
         if (rslot(h, v)) begin
            en_m   = 1'b1;
            addr_m = {front_m, 17'((tv / 2) * 320 + th / 2)};
         end else if (bus.wr_valid) begin
            if (int'(bus.wr_addr) < 76800) begin
               en_m    = 1'b1;
               we_m    = 1'b1;
               addr_m  = {!front_m, bus.wr_addr};
               wdata_m = bus.wr_data;
               fb_ref[!front_m][bus.wr_addr] = bus.wr_data;
            end
            if (mode != 0) seq++;
         end
         if (h == 799 && v == 479 && (pend_m || sreq)) begin
            front_m = !front_m;
            pend_m  = 1'b0;
            done_m  = 1'b1;
         end else if (sreq) pend_m = 1'b1;
      end
      @(negedge vgaclk);
      chk("ram_en", 32'(bus.ram_en), 32'(en_m));
      chk("ram_we", 32'(bus.ram_we), 32'(we_m));
      if (en_m) chk("ram_addr", 32'(bus.ram_addr), 32'(addr_m));
      if (en_m && we_m) chk("ram_wdata", 32'(bus.ram_wdata), 32'(wdata_m));
      chk("front_buf", 32'(bus.front_buf), 32'(front_m));
      chk("swap_pending", 32'(bus.swap_pending), 32'(pend_m));
      chk("swap_done", 32'(bus.swap_done), 32'(done_m));
      h++;
      if (h == 800) begin
         h = 0;
         v = (v + 1) % 525;
      end
      cont = rst ? cont + 1 : 0;
   endtask

   task automatic run(input int n, input int sh, input int sv);
      for (int i = 0; i < n; i++) cycle(h == sh && v == sv, 1'b0);
   endtask

   task automatic jump(input int hh, input int vv);
      h = hh;
      v = vv;
      cont = 0;
   endtask

   initial begin
      for (int y = 0; y < 240; y++)
         for (int x = 0; x < 320; x++) begin
            fb_ref[0][y * 320 + x] = 8'(x ^ y);
            fb_ref[1][y * 320 + x] = 8'(x * 3 + y) ^ 8'ha5;
            mem[y * 320 + x] = 8'(x ^ y);
            mem[131072 + y * 320 + x] = 8'(x * 3 + y) ^ 8'ha5;
         end
      bus.ram_rdata = 8'h00;
      rst = 1'b0;
      run(3, -1, -1);
      zero_checks();
      rst = 1'b1;
      // frame wrap into the top of the frame, random writer
      jump(780, 523);
      run(800 * 5, -1, -1);
      // writer always requesting, sequential addresses
      mode = 1;
      seq = 0;
      jump(600, 10);
      run(1600, -1, -1);
      // out-of-range writes are accepted but dropped
      seq = 76800;
      jump(650, 20);
      run(40, -1, -1);
      mode = 0;
      // swap requested mid-frame, applied at end of last visible line
      jump(0, 99);
      run(1700, 5, 100);
      jump(700, 478);
      run(1000, -1, -1);
      jump(780, 523);
      run(800 * 3, -1, -1);
      // swap requested exactly on the swap edge
      jump(790, 479);
      run(20, 799, 479);
      // repeated requests while pending give a single toggle
      jump(0, 200);
      run(10, 3, 200);
      jump(0, 300);
      run(10, 3, 300);
      jump(790, 479);
      run(20, -1, -1);
      jump(780, 524);
      run(800 * 3, -1, -1);
      // asynchronous reset in the middle of an active line
      jump(295, 200);
      run(5, -1, -1);
      cycle(1'b0, 1'b1);
      run(3, -1, -1);
      rst = 1'b1;
      run(800 * 3, -1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
